// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL bring-up supervisor.
package pll_sup_pkg;

    localparam int CNT_W   = 16;
    localparam int RETRY_W = 2;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        if (v == {RETRY_W{1'b1}}) begin
            retry_inc = v;
        end else begin
            retry_inc = v + RETRY_W'(1);
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic areset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // capture the asynchronous level, then re-time it once more
    always_ff @(posedge clk) begin
        if (areset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_supervisor.sv
// Sequences PLL reset, lock qualification and staggered per-domain reset
// release, with bounded retries on lock loss or lock timeout.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGGER       = 8,
    parameter int MAX_RETRIES   = 3,
    parameter int N_DOM         = 4
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_areset,
    output logic [N_DOM-1:0]   domain_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    state_t             state_r;
    logic [CNT_W-1:0]   timer_r;
    logic [IDX_W-1:0]   idx_r;
    logic               pll_areset_r;
    logic [N_DOM-1:0]   domain_rst_r;
    logic               ready_r;
    logic               fail_r;
    logic [RETRY_W-1:0] retry_cnt_r;

    logic lock_s;
    logic lock_lost_s;
    logic timeout_s;
    logic retry_s;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .areset (areset),
        .d      (pll_locked),
        .q      (lock_s)
    );

    // events that send the sequence down the retry path this cycle
    always_comb begin
        lock_lost_s = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                if (!lock_s && (timer_r == CNT_W'(LOCK_TIMEOUT - 1))) begin
                    timeout_s = 1'b1;
                end else begin
                    timeout_s = 1'b0;
                end
            end
            RELEASE, RUN: begin
                if (!lock_s) begin
                    lock_lost_s = 1'b1;
                end else begin
                    lock_lost_s = 1'b0;
                end
            end
            default: begin
                lock_lost_s = 1'b0;
                timeout_s   = 1'b0;
            end
        endcase
        retry_s = lock_lost_s | timeout_s;
    end

    // sequencer: state, timer, domain index and every registered output
    always_ff @(posedge clk) begin
        if (areset || restart) begin
            // a restart lands in exactly the same place as a block reset
            state_r      <= RESET_PLL;
            timer_r      <= CNT_W'(0);
            idx_r        <= IDX_W'(0);
            pll_areset_r <= 1'b1;
            domain_rst_r <= {N_DOM{1'b1}};
            ready_r      <= 1'b0;
            fail_r       <= 1'b0;
            retry_cnt_r  <= RETRY_W'(0);
        end else if (retry_s) begin
            timer_r      <= CNT_W'(0);
            idx_r        <= IDX_W'(0);
            pll_areset_r <= 1'b1;
            domain_rst_r <= {N_DOM{1'b1}};
            ready_r      <= 1'b0;
            if (retry_cnt_r == RETRY_W'(MAX_RETRIES)) begin
                state_r <= FAIL;
                fail_r  <= 1'b1;
            end else begin
                state_r     <= RESET_PLL;
                retry_cnt_r <= retry_inc(retry_cnt_r);
                fail_r      <= 1'b0;
            end
        end else begin
            case (state_r)
                RESET_PLL: begin
                    if (timer_r == CNT_W'(RST_CYCLES - 1)) begin
                        state_r      <= WAIT_LOCK;
                        timer_r      <= CNT_W'(0);
                        pll_areset_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_r <= STABLE;
                        timer_r <= CNT_W'(0);
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_r <= WAIT_LOCK;
                        timer_r <= CNT_W'(0);
                    end else if (timer_r == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_r <= RELEASE;
                        timer_r <= CNT_W'(0);
                        idx_r   <= IDX_W'(0);
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (timer_r == CNT_W'(STAGGER - 1)) begin
                        domain_rst_r[idx_r] <= 1'b0;
                        idx_r               <= idx_r + IDX_W'(1);
                        timer_r             <= CNT_W'(0);
                        if (idx_r == IDX_W'(N_DOM - 1)) begin
                            state_r <= RUN;
                            ready_r <= 1'b1;
                        end else begin
                            state_r <= RELEASE;
                        end
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                RUN: begin
                    ready_r <= 1'b1;
                end
                FAIL: begin
                    pll_areset_r <= 1'b1;
                    domain_rst_r <= {N_DOM{1'b1}};
                    fail_r       <= 1'b1;
                end
                default: begin
                    state_r      <= RESET_PLL;
                    timer_r      <= CNT_W'(0);
                    idx_r        <= IDX_W'(0);
                    pll_areset_r <= 1'b1;
                    domain_rst_r <= {N_DOM{1'b1}};
                    ready_r      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_areset = pll_areset_r;
    assign domain_rst = domain_rst_r;
    assign ready      = ready_r;
    assign fail       = fail_r;
    assign retry_cnt  = retry_cnt_r;

endmodule

// File: tb/tb_pll_supervisor.sv
// Self-checking bench for pll_supervisor: directed vector table, corner-case
// sequences and a randomized run against a cycle-level behavioural model.
module tb_pll_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int STAGGER       = 2;
    localparam int MAX_RETRIES   = 2;
    localparam int N_DOM         = 4;

    logic       clk = 1'b0;
    logic       areset;
    logic       pll_locked;
    logic       restart;
    logic       pll_areset;
    logic [3:0] domain_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;

    pll_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .STAGGER       (STAGGER),
        .MAX_RETRIES   (MAX_RETRIES),
        .N_DOM         (N_DOM)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_areset (pll_areset),
        .domain_rst (domain_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: phase of the bring-up, cycles spent in it, number of
    // domains released so far, retries used; lock is seen two edges late.
    localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_REL = 3, P_RUN = 4, P_FAIL = 5;
    int m_phase, m_elapsed, m_released, m_retries;
    bit m_fail, m_pa, m_ready;
    bit lq[$] = '{1'b0, 1'b0};

    task automatic model_restart();
        m_phase = P_RST; m_elapsed = 0; m_released = 0; m_retries = 0;
        m_fail = 1'b0; m_pa = 1'b1; m_ready = 1'b0;
    endtask

    task automatic model_edge(input bit ar, input bit rs, input bit pl);
        bit ls;
        bool_dummy: begin end
        if (ar) begin
            model_restart();
            lq.delete();
            lq.push_back(1'b0);
            lq.push_back(1'b0);
        end else begin
            ls = lq.pop_front();
            lq.push_back(pl);
            if (rs) begin
                model_restart();
            end else if ((!ls && (m_phase == P_REL || m_phase == P_RUN)) ||
                         (!ls && m_phase == P_WAIT && m_elapsed + 1 == LOCK_TIMEOUT)) begin
                m_released = 0; m_ready = 1'b0; m_elapsed = 0; m_pa = 1'b1;
                if (m_retries == MAX_RETRIES) begin
                    m_phase = P_FAIL; m_fail = 1'b1;
                end else begin
                    m_retries++; m_phase = P_RST;
                end
            end else begin
                case (m_phase)
                    P_RST: begin
                        m_elapsed++;
                        if (m_elapsed == RST_CYCLES) begin
                            m_phase = P_WAIT; m_elapsed = 0; m_pa = 1'b0;
                        end
                    end
                    P_WAIT: begin
                        if (ls) begin m_phase = P_STABLE; m_elapsed = 0; end
                        else m_elapsed++;
                    end
                    P_STABLE: begin
                        if (!ls) begin
                            m_phase = P_WAIT; m_elapsed = 0;
                        end else begin
                            m_elapsed++;
                            if (m_elapsed == STABLE_CYCLES) begin m_phase = P_REL; m_elapsed = 0; end
                        end
                    end
                    P_REL: begin
                        m_elapsed++;
                        if (m_elapsed == STAGGER) begin
                            m_elapsed = 0;
                            m_released++;
                            if (m_released == N_DOM) begin m_phase = P_RUN; m_ready = 1'b1; end
                        end
                    end
                    default: begin end
                endcase
            end
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [3:0] m;
        m = 4'hF;
        m = m << m_released;
        return {m_pa, m, m_ready, m_fail, 2'(m_retries)};
    endfunction

    task automatic chk_vec(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual{pa,rst,rdy,fail,rc}=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input bit ar, input bit rs, input bit pl, input bit cmp_model, input string tag);
        areset = ar; restart = rs; pll_locked = pl;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(ar, rs, pl);
        if (cmp_model) chk_vec(tag, {pll_areset, domain_rst, ready, fail, retry_cnt}, model_out());
    endtask

    typedef struct {
        int         n;
        bit         ar, rs, pl;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(int n, bit ar, bit rs, bit pl,
                                bit pa, logic [3:0] dr, bit rdy, bit f, logic [1:0] rc);
        vec_t v;
        v.n = n; v.ar = ar; v.rs = rs; v.pl = pl;
        v.exp = {pa, dr, rdy, f, rc};
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   first;
        bit   pl_r;

        areset = 1'b1; restart = 1'b0; pll_locked = 1'b0;

        // nominal bring-up, lock loss in RUN, restart vs lock loss, areset in RELEASE
        tbl.push_back(mk( 1, 1, 0, 0, 1, 4'hF, 0, 0, 2'd0));
        tbl.push_back(mk( 3, 0, 0, 0, 1, 4'hF, 0, 0, 2'd0));
        tbl.push_back(mk( 3, 0, 0, 0, 0, 4'hF, 0, 0, 2'd0));
        tbl.push_back(mk(12, 0, 0, 1, 0, 4'hF, 0, 0, 2'd0));
        tbl.push_back(mk( 2, 0, 0, 1, 0, 4'hE, 0, 0, 2'd0));
        tbl.push_back(mk( 2, 0, 0, 1, 0, 4'hC, 0, 0, 2'd0));
        tbl.push_back(mk( 2, 0, 0, 1, 0, 4'h8, 0, 0, 2'd0));
        tbl.push_back(mk( 3, 0, 0, 1, 0, 4'h0, 1, 0, 2'd0));
        tbl.push_back(mk( 2, 0, 0, 0, 0, 4'h0, 1, 0, 2'd0));
        tbl.push_back(mk( 4, 0, 0, 0, 1, 4'hF, 0, 0, 2'd1));
        tbl.push_back(mk(12, 0, 0, 1, 0, 4'hF, 0, 0, 2'd1));
        tbl.push_back(mk( 2, 0, 0, 1, 0, 4'hE, 0, 0, 2'd1));
        tbl.push_back(mk( 2, 0, 0, 1, 0, 4'hC, 0, 0, 2'd1));
        tbl.push_back(mk( 2, 0, 0, 1, 0, 4'h8, 0, 0, 2'd1));
        tbl.push_back(mk( 2, 0, 0, 1, 0, 4'h0, 1, 0, 2'd1));
        tbl.push_back(mk( 2, 0, 0, 0, 0, 4'h0, 1, 0, 2'd1));
        tbl.push_back(mk( 1, 0, 1, 0, 1, 4'hF, 0, 0, 2'd0));
        tbl.push_back(mk( 3, 0, 0, 1, 1, 4'hF, 0, 0, 2'd0));
        tbl.push_back(mk(11, 0, 0, 1, 0, 4'hF, 0, 0, 2'd0));
        tbl.push_back(mk( 2, 0, 0, 1, 0, 4'hE, 0, 0, 2'd0));
        tbl.push_back(mk( 1, 0, 0, 1, 0, 4'hC, 0, 0, 2'd0));
        tbl.push_back(mk( 1, 1, 0, 1, 1, 4'hF, 0, 0, 2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].ar, tbl[i].rs, tbl[i].pl, 1'b0, "table");
                chk_vec($sformatf("table_row%0d", i),
                        {pll_areset, domain_rst, ready, fail, retry_cnt}, tbl[i].exp);
            end
        end

        // one-cycle lock glitch while qualifying stability delays release by a full window
        step(1'b1, 1'b0, 1'b1, 1'b1, "glitch_rst");
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b0, (i == 10) ? 1'b0 : 1'b1, 1'b1, "glitch");
            if (ready && first < 0) first = i;
        end
        chk_int("glitch_ready_cycle", first, 29);
        chk_int("glitch_retry_cnt", int'(retry_cnt), 0);

        // lock never arrives: two retries, then failure on the third timeout
        step(1'b1, 1'b0, 1'b0, 1'b1, "nolock_rst");
        first = -1;
        for (int i = 1; i <= 80; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, "nolock");
            if (i == 24) chk_int("nolock_retry1", int'(retry_cnt), 1);
            if (i == 48) chk_int("nolock_retry2", int'(retry_cnt), 2);
            if (fail && first < 0) first = i;
        end
        chk_int("nolock_fail_cycle", first, 72);
        chk_vec("nolock_final", {pll_areset, domain_rst, ready, fail, retry_cnt}, 9'b1_1111_0_1_10);

        // restart out of failure with a healthy PLL
        step(1'b0, 1'b1, 1'b1, 1'b1, "restart");
        chk_vec("restart_state", {pll_areset, domain_rst, ready, fail, retry_cnt}, 9'b1_1111_0_0_00);
        first = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, "restart_seq");
            if (ready && first < 0) first = i;
        end
        chk_int("restart_ready_cycle", first, 21);

        // randomized lock behaviour with occasional restart and block reset
        step(1'b1, 1'b0, 1'b0, 1'b1, "rand_rst");
        pl_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) pl_r = ~pl_r;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 199) == 0) ? ~pl_r : pl_r, 1'b1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
